// File: rtl/regfile_wb_ctrl.sv
// Merges ALU writeback (priority, 1-cycle) with FIFO-buffered load/mul-div results (2-cycle min) onto one regfile write port.
// B is throttled by b_ready when the FIFO is full; A is stalled for one cycle after STARVE_MAX consecutive head bypasses.
module regfile_wb_ctrl #(
    parameter int DEPTH      = 4,
    parameter int STARVE_MAX = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        a_valid,
    input  logic [4:0]  a_reg,
    input  logic [31:0] a_data,
    output logic        a_stall,
    input  logic        b_valid,
    output logic        b_ready,
    input  logic [4:0]  b_reg,
    input  logic [31:0] b_data,
    output logic        RegWrite,
    output logic [4:0]  Wreg,
    output logic [31:0] Wdata,
    output logic [31:0] pend_mask
);
    localparam int AW = $clog2(DEPTH);
    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [AW:0]   L_FULL   = (AW + 1)'(DEPTH);
    localparam logic [SW-1:0] L_STARVE = SW'(STARVE_MAX);

    typedef struct packed {
        logic        live;
        logic [4:0]  rg;
        logic [31:0] dat;
    } entry_t;

    entry_t        r_fifo [DEPTH];
    logic [AW-1:0] r_rd_ptr;
    logic [AW-1:0] r_wr_ptr;
    logic [AW:0]   r_count;
    logic [SW-1:0] r_starve;
    logic          r_a_stall;
    logic          r_reg_write;
    logic [4:0]    r_wreg;
    logic [31:0]   r_wdata;

    logic          w_a_win;
    logic          w_empty;
    logic          w_full;
    logic          w_pop;
    logic          w_push;
    entry_t        w_head;
    logic [SW-1:0] w_starve_nxt;
    logic [31:0]   w_pend_mask;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == L_FULL);
    assign w_a_win = a_valid && !r_a_stall && (a_reg != 5'd0);
    assign w_pop   = !w_a_win && !w_empty;
    assign b_ready = !rst && !w_full;
    assign w_push  = b_valid && b_ready;
    assign w_head  = r_fifo[r_rd_ptr];

    // The counter only measures bypasses of a waiting head, so any pop or an empty queue restarts it.
    always_comb begin
        w_starve_nxt = r_starve;
        if (w_empty || w_pop) begin
            w_starve_nxt = '0;
        end else if (w_a_win) begin
            w_starve_nxt = r_starve + 1'b1;
        end
    end

    always_comb begin
        w_pend_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_fifo[i].live) begin
                w_pend_mask[r_fifo[i].rg] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_fifo[i] <= '0;
            end
            r_rd_ptr    <= '0;
            r_wr_ptr    <= '0;
            r_count     <= '0;
            r_starve    <= '0;
            r_a_stall   <= 1'b0;
            r_reg_write <= 1'b0;
            r_wreg      <= '0;
            r_wdata     <= '0;
        end else begin
            // WAW kill runs before the push so a same-cycle B entry (younger) survives.
            if (w_a_win) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (r_fifo[i].live && (r_fifo[i].rg == a_reg)) begin
                        r_fifo[i].live <= 1'b0;
                    end
                end
            end
            if (w_pop) begin
                r_fifo[r_rd_ptr].live <= 1'b0;
                r_rd_ptr              <= r_rd_ptr + 1'b1;
            end
            if (w_push) begin
                r_fifo[r_wr_ptr] <= '{live: (b_reg != 5'd0), rg: b_reg, dat: b_data};
                r_wr_ptr         <= r_wr_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            r_starve  <= w_starve_nxt;
            r_a_stall <= !r_a_stall && (w_starve_nxt == L_STARVE);

            if (w_a_win) begin
                r_reg_write <= 1'b1;
                r_wreg      <= a_reg;
                r_wdata     <= a_data;
            end else if (w_pop && w_head.live) begin
                r_reg_write <= 1'b1;
                r_wreg      <= w_head.rg;
                r_wdata     <= w_head.dat;
            end else begin
                r_reg_write <= 1'b0;
            end
        end
    end

    assign a_stall   = r_a_stall;
    assign RegWrite  = r_reg_write;
    assign Wreg      = r_wreg;
    assign Wdata     = r_wdata;
    assign pend_mask = w_pend_mask;

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Directed bench for regfile_wb_ctrl: inputs change 1ns after the rising edge, outputs checked at that point.
module tb_regfile_wb_ctrl;
    logic        clk;
    logic        rst;
    logic        a_valid;
    logic [4:0]  a_reg;
    logic [31:0] a_data;
    logic        a_stall;
    logic        b_valid;
    logic        b_ready;
    logic [4:0]  b_reg;
    logic [31:0] b_data;
    logic        RegWrite;
    logic [4:0]  Wreg;
    logic [31:0] Wdata;
    logic [31:0] pend_mask;

    int n_checks = 0;
    int n_fail   = 0;

    regfile_wb_ctrl #(.DEPTH(4), .STARVE_MAX(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .a_valid   (a_valid),
        .a_reg     (a_reg),
        .a_data    (a_data),
        .a_stall   (a_stall),
        .b_valid   (b_valid),
        .b_ready   (b_ready),
        .b_reg     (b_reg),
        .b_data    (b_data),
        .RegWrite  (RegWrite),
        .Wreg      (Wreg),
        .Wdata     (Wdata),
        .pend_mask (pend_mask)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_wr(input string tag, input logic we, input logic [4:0] rg, input logic [31:0] dat);
        check({tag, ".RegWrite"}, 32'(RegWrite), 32'(we));
        check({tag, ".Wreg"},     32'(Wreg),     32'(rg));
        check({tag, ".Wdata"},    Wdata,         dat);
    endtask

    initial begin
        rst = 1'b1; a_valid = 1'b0; a_reg = '0; a_data = '0;
        b_valid = 1'b0; b_reg = '0; b_data = '0;

        // Reset then idle
        step();
        check("rst.b_ready_low", 32'(b_ready), 32'd0);
        step();
        rst = 1'b0;
        step();
        check_wr("idle", 1'b0, 5'd0, 32'h0);
        check("idle.a_stall", 32'(a_stall), 32'd0);
        check("idle.pend_mask", pend_mask, 32'h0);
        check("idle.b_ready", 32'(b_ready), 32'd1);

        // A only, including a write to r0
        a_valid = 1'b1; a_reg = 5'd5; a_data = 32'hDEADBEEF;
        step();
        check_wr("a5", 1'b1, 5'd5, 32'hDEADBEEF);
        a_reg = 5'd0; a_data = 32'h1234;
        step();
        check_wr("a0", 1'b0, 5'd5, 32'hDEADBEEF);

        // Fill: A keeps winning on r20 so the queue cannot drain
        a_reg = 5'd20; a_data = 32'hA20;
        for (int k = 1; k <= 4; k++) begin
            b_valid = 1'b1; b_reg = 5'(k); b_data = 32'(100 + k);
            step();
            check_wr("fill", 1'b1, 5'd20, 32'hA20);
        end
        check("full.b_ready", 32'(b_ready), 32'd0);
        check("full.pend_mask", pend_mask, 32'h1E);
        b_reg = 5'd5; b_data = 32'd105;
        step();
        check("full_hold.b_ready", 32'(b_ready), 32'd0);
        check("full_hold.pend_mask", pend_mask, 32'h1E);

        // Drain in order
        a_valid = 1'b0; b_valid = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            step();
            check_wr("drain", 1'b1, 5'(k), 32'(100 + k));
            check("drain.b_ready", 32'(b_ready), 32'd1);
        end
        check("drain.pend_mask", pend_mask, 32'h0);
        step();
        check("drain_done.RegWrite", 32'(RegWrite), 32'd0);

        // WAW kill
        b_valid = 1'b1; b_reg = 5'd7; b_data = 32'h11;
        step();
        check("waw.pend_set", pend_mask, 32'h80);
        b_valid = 1'b0;
        a_valid = 1'b1; a_reg = 5'd7; a_data = 32'h22;
        step();
        check_wr("waw.a", 1'b1, 5'd7, 32'h22);
        check("waw.pend_clr", pend_mask, 32'h0);
        a_valid = 1'b0;
        step();
        check_wr("waw.killed_pop", 1'b0, 5'd7, 32'h22);
        step();
        check("waw.quiet", 32'(RegWrite), 32'd0);

        // Starvation: B r9 waits behind continuous A traffic
        b_valid = 1'b1; b_reg = 5'd9; b_data = 32'h99;
        a_valid = 1'b1; a_reg = 5'd10; a_data = 32'h1010;
        step();
        check_wr("starve.a10", 1'b1, 5'd10, 32'h1010);
        b_valid = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            a_reg = 5'(10 + k); a_data = 32'h1000 + 32'(10 + k);
            step();
            check_wr("starve.a", 1'b1, 5'(10 + k), 32'h1000 + 32'(10 + k));
            check("starve.a_stall", 32'(a_stall), 32'(k == 8));
        end
        a_reg = 5'd19; a_data = 32'h1019;
        step();
        check_wr("starve.b9", 1'b1, 5'd9, 32'h99);
        check("starve.stall_drop", 32'(a_stall), 32'd0);
        check("starve.pend", pend_mask, 32'h0);
        step();
        check_wr("starve.held_a", 1'b1, 5'd19, 32'h1019);
        a_valid = 1'b0;
        step();
        check("starve.quiet", 32'(RegWrite), 32'd0);

        // Reset mid-operation with three live entries queued
        a_valid = 1'b1; a_reg = 5'd21; a_data = 32'hA21;
        for (int k = 12; k <= 14; k++) begin
            b_valid = 1'b1; b_reg = 5'(k); b_data = 32'(k);
            step();
        end
        check("mid.pend", pend_mask, 32'h7000);
        rst = 1'b1; a_valid = 1'b0; b_valid = 1'b0;
        step();
        check("mid.rst.RegWrite", 32'(RegWrite), 32'd0);
        check("mid.rst.pend", pend_mask, 32'h0);
        check("mid.rst.b_ready", 32'(b_ready), 32'd0);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            check_wr("mid.after", 1'b0, 5'd0, 32'h0);
            check("mid.after.pend", pend_mask, 32'h0);
            check("mid.after.b_ready", 32'(b_ready), 32'd1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
